// File: rtl/audio_mixer_n.sv
// rtl/audio_mixer_n.sv - N-channel sequential audio mixer with per-channel volume/mute
// Optional MIXER_SATURATE_EN: clamp overflowing mixes to all-ones instead of wrapping.
module audio_mixer_n #(
  parameter int NUM_CHANNELS = 3,
  parameter int IN_WIDTH     = 9,
  parameter int OUT_WIDTH    = 8,
  parameter int VOL_WIDTH    = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_sample_stb,
  input  logic [NUM_CHANNELS*IN_WIDTH-1:0]  i_channels,
  input  logic [NUM_CHANNELS*VOL_WIDTH-1:0] i_volumes,
  input  logic [NUM_CHANNELS-1:0]           i_mute,
  output logic [OUT_WIDTH-1:0]              o_sample,
  output logic                              o_sample_valid,
  output logic                              o_busy,
  output logic                              o_clipped,
  output logic                              o_overrun
);

  localparam int CNT_W  = $clog2(NUM_CHANNELS);
  localparam int IDX_W  = (NUM_CHANNELS > 1) ? CNT_W : 1;
  localparam int PROD_W = IN_WIDTH + VOL_WIDTH + 1;
  localparam int ACC_W  = IN_WIDTH + VOL_WIDTH + CNT_W + 1;
  localparam int MIX_W  = ACC_W - VOL_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx;
  logic [ACC_W-1:0]        acc;
  logic [IN_WIDTH-1:0]     ch_snap  [NUM_CHANNELS];
  logic [VOL_WIDTH-1:0]    vol_snap [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mute_snap;
  logic [PROD_W-1:0]       term;
  logic [MIX_W-1:0]        mix;
  logic                    overflow;
  logic [OUT_WIDTH-1:0]    sample_next;
  logic                    last_idx;

  assign last_idx = (idx == IDX_W'(NUM_CHANNELS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_sample_stb) state_next = ACCUM;
      ACCUM:   if (last_idx)     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  // vol+1 makes all-ones volume a x2^VOL_WIDTH gain, undone by the shift in DONE
  always_comb begin
    term = '0;
    if (!mute_snap[idx])
      term = PROD_W'(ch_snap[idx]) * PROD_W'({1'b0, vol_snap[idx]} + 1'b1);
  end

  assign mix      = acc[ACC_W-1:VOL_WIDTH];
  assign overflow = (mix > MIX_W'((2 ** OUT_WIDTH) - 1));

`ifdef MIXER_SATURATE_EN
  assign sample_next = overflow ? '1 : mix[OUT_WIDTH-1:0];
`else
  assign sample_next = mix[OUT_WIDTH-1:0];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_clipped      <= 1'b0;
      o_overrun      <= 1'b0;
      acc            <= '0;
      idx            <= '0;
      mute_snap      <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        ch_snap[k]  <= '0;
        vol_snap[k] <= '0;
      end
    end else begin
      o_sample_valid <= 1'b0;
      // Strobes arriving mid-mix (DONE included) are dropped, never queued
      if (i_sample_stb && state != IDLE) o_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (i_sample_stb) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
              ch_snap[k]  <= i_channels[k*IN_WIDTH +: IN_WIDTH];
              vol_snap[k] <= i_volumes[k*VOL_WIDTH +: VOL_WIDTH];
            end
            mute_snap <= i_mute;
            acc       <= '0;
            idx       <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(term);
          idx <= idx + 1'b1;
        end
        DONE: begin
          o_sample       <= sample_next;
          o_clipped      <= overflow;
          o_sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer_n.sv
// tb/tb_audio_mixer_n.sv - directed self-checking bench for audio_mixer_n
module tb_audio_mixer_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [26:0] channels;
  logic [11:0] volumes;
  logic [2:0]  mute;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        busy;
  logic        clipped;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  audio_mixer_n dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample_stb   (stb),
    .i_channels     (channels),
    .i_volumes      (volumes),
    .i_mute         (mute),
    .o_sample       (sample),
    .o_sample_valid (sample_valid),
    .o_busy         (busy),
    .o_clipped      (clipped),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic set_inputs(input int c0, input int c1, input int c2,
                            input int v0, input int v1, input int v2, input logic [2:0] m);
    channels = {9'(c2), 9'(c1), 9'(c0)};
    volumes  = {4'(v2), 4'(v1), 4'(v0)};
    mute     = m;
  endtask

  // Strobe once, then watch 8 cycles; reports first valid cycle offset and pulse count
  task automatic run_mix(output int first_valid, output int pulses,
                         output logic [7:0] smp, output logic clp);
    first_valid = -1;
    pulses = 0;
    smp = '0;
    clp = 1'b0;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (sample_valid) begin
        pulses++;
        if (first_valid < 0) begin
          first_valid = k;
          smp = sample;
          clp = clipped;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    stb = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 3'b000);
    repeat (2) @(negedge clk);
    checks++;
    if ({sample, sample_valid, busy, clipped, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got sample=%0d valid=%b busy=%b clip=%b ovr=%b, want all 0",
               sample, sample_valid, busy, clipped, overrun);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d busy=%b valid=%b, want 0 0", k, busy, sample_valid);
      end
    end
  endtask

  task automatic test_basic_mix;
    set_inputs(100, 50, 20, 15, 15, 15, 3'b000);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (busy !== (k <= 4)) begin
        errors++;
        $display("FAIL basic_busy: T+%0d busy=%b, want %b", k, busy, (k <= 4));
      end
      checks++;
      if (sample_valid !== (k == 5)) begin
        errors++;
        $display("FAIL basic_valid: T+%0d valid=%b, want %b", k, sample_valid, (k == 5));
      end
      if (k == 5) begin
        checks++;
        if (sample !== 8'd170 || clipped !== 1'b0) begin
          errors++;
          $display("FAIL basic_value: sample=%0d clip=%b, want 170 0", sample, clipped);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clip;
    int fv, np;
    logic [7:0] s;
    logic c;
    logic [7:0] want;
`ifdef MIXER_SATURATE_EN
    want = 8'd255;
`else
    want = 8'd44;
`endif
    set_inputs(200, 100, 0, 15, 15, 15, 3'b000);
    run_mix(fv, np, s, c);
    checks++;
    if (fv != 5 || np != 1 || s !== want || c !== 1'b1) begin
      errors++;
      $display("FAIL clip_mix: lat=%0d pulses=%0d sample=%0d clip=%b, want 5 1 %0d 1",
               fv, np, s, c, want);
    end
    checks++;
    if (clipped !== 1'b1 || sample !== want) begin
      errors++;
      $display("FAIL clip_hold: sample=%0d clip=%b, want %0d 1", sample, clipped, want);
    end
  endtask

  task automatic test_volume_mute_snapshot;
    int first_valid = -1;
    logic [7:0] s = '0;
    logic c = 1'b1;
    set_inputs(100, 300, 400, 7, 15, 15, 3'b110);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) set_inputs(511, 511, 511, 15, 15, 15, 3'b000);
      if (sample_valid && first_valid < 0) begin
        first_valid = k;
        s = sample;
        c = clipped;
      end
      @(negedge clk);
    end
    checks++;
    if (first_valid != 5 || s !== 8'd50 || c !== 1'b0) begin
      errors++;
      $display("FAIL vol_mute_snapshot: lat=%0d sample=%0d clip=%b, want 5 50 0", first_valid, s, c);
    end
  endtask

  task automatic test_back_to_back;
    int fv, np;
    int pulses = 0;
    logic [7:0] s = '0;
    logic [7:0] s2;
    logic c;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: overrun=%b, want 0", overrun);
    end
    set_inputs(100, 50, 20, 15, 15, 15, 3'b000);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (sample_valid) begin
        pulses++;
        s = sample;
      end
      if (k == 2 || k == 4) begin
        set_inputs(10, 10, 10, 15, 15, 15, 3'b000);
        stb = 1'b1;
      end else begin
        stb = 1'b0;
      end
      @(negedge clk);
    end
    stb = 1'b0;
    checks++;
    if (pulses != 1 || s !== 8'd170) begin
      errors++;
      $display("FAIL overrun_single: pulses=%0d sample=%0d, want 1 170", pulses, s);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b, want 1", overrun);
    end
    set_inputs(100, 300, 400, 7, 15, 15, 3'b110);
    run_mix(fv, np, s2, c);
    checks++;
    if (fv != 5 || np != 1 || s2 !== 8'd50 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_recover: lat=%0d pulses=%0d sample=%0d ovr=%b, want 5 1 50 1",
               fv, np, s2, overrun);
    end
  endtask

  task automatic test_reset_mid_mix;
    int fv, np;
    int pulses = 0;
    logic [7:0] s;
    logic c;
    set_inputs(200, 200, 200, 15, 15, 15, 3'b000);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || sample !== 8'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b sample=%0d ovr=%b, want 0 0 0", busy, sample, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (sample_valid) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_valid: pulses=%0d, want 0", pulses);
    end
    set_inputs(100, 50, 20, 15, 15, 15, 3'b000);
    run_mix(fv, np, s, c);
    checks++;
    if (fv != 5 || np != 1 || s !== 8'd170 || c !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: lat=%0d pulses=%0d sample=%0d clip=%b, want 5 1 170 0",
               fv, np, s, c);
    end
  endtask

  initial begin
    test_reset;
    test_basic_mix;
    test_clip;
    test_volume_mute_snapshot;
    test_back_to_back;
    test_reset_mid_mix;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_mixer_n.md
Name: audio_mixer_n

Overview:
Parametrised N-channel audio mixer that replaces the fixed three-input adder at the top level. On each sample strobe it snapshots all channel outputs, then accumulates them sequentially, one channel per clock. Each channel has a per-channel volume and mute. The summed result is scaled, range-limited to the DAC sample width and registered, with a valid pulse. It sits between the channel_* generators and the audio sample output.

Parameters:
NUM_CHANNELS, 3, number of input channels (>=1)
IN_WIDTH, 9, unsigned width of each channel sample
OUT_WIDTH, 8, unsigned width of mixed output sample
VOL_WIDTH, 4, width of each per-channel volume field

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-high
i_sample_stb  input  1  one-cycle request to mix a new sample
i_channels  input  NUM_CHANNELS*IN_WIDTH  packed channel samples; channel k at [k*IN_WIDTH +: IN_WIDTH]
i_volumes  input  NUM_CHANNELS*VOL_WIDTH  packed volumes; channel k at [k*VOL_WIDTH +: VOL_WIDTH]
i_mute  input  NUM_CHANNELS  bit k=1 forces channel k contribution to 0
o_sample  output  OUT_WIDTH  mixed sample, held between updates
o_sample_valid  output  1  one-cycle pulse when o_sample updates
o_busy  output  1  high while a mix is in progress
o_clipped  output  1  valid with o_sample_valid; high when the scaled sum exceeded 2^OUT_WIDTH-1
o_overrun  output  1  sticky; set when a strobe is dropped, cleared only by reset

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-high on i_rst.
- Reset values: o_sample=0, o_sample_valid=0, o_busy=0, o_clipped=0, o_overrun=0, FSM=IDLE, accumulator=0, channel index=0.
- FSM states: IDLE, ACCUM, DONE. o_busy = (state != IDLE).
- IDLE:
  - If i_sample_stb is high, latch i_channels, i_volumes and i_mute into snapshot registers.
  - Clear the accumulator, set index=0 and go to ACCUM.
  - Inputs are sampled only in this cycle; later changes do not affect the current mix.
- ACCUM:
  - Each cycle, acc += mute[idx] ? 0 : ch[idx]*(vol[idx]+1), then idx++.
  - After idx = NUM_CHANNELS-1 is added, go to DONE.
  - ACCUM lasts exactly NUM_CHANNELS cycles.
- DONE:
  - mix = acc >> VOL_WIDTH, giving unity gain at vol = all-ones.
  - If mix > 2^OUT_WIDTH-1, apply the range-limit rule (see Optional Feature) and register o_clipped=1; otherwise o_sample=mix[OUT_WIDTH-1:0] and o_clipped=0.
  - Pulse o_sample_valid for one cycle and return to IDLE.
- Latency: strobe in cycle T gives o_sample_valid high in cycle T+NUM_CHANNELS+2. With the defaults, valid is high at T+5.
- Maximum strobe rate: one per NUM_CHANNELS+2 cycles.
- Accumulator width: IN_WIDTH+VOL_WIDTH+clog2(NUM_CHANNELS)+1. It must never wrap internally.
- Strobe while o_busy=1, including in the DONE cycle: the strobe is ignored, o_overrun is set, and the in-flight mix is unaffected.
- o_clipped holds its value until the next o_sample_valid. o_sample holds between updates.
- i_rst mid-mix: abort immediately to the reset state. No valid pulse is produced for the aborted mix.
- All arithmetic is unsigned.

Optional Feature:
Macro MIXER_SATURATE_EN.
- Defined: an overflowing mix outputs all-ones (2^OUT_WIDTH-1).
- Undefined: an overflowing mix outputs mix[OUT_WIDTH-1:0] (wrap, legacy truncation behaviour).
- o_clipped reports the overflow in both builds.

Test Plan:
1. Reset with defaults -> o_sample=0, o_sample_valid=0, o_busy=0, o_clipped=0, o_overrun=0. After release, with no strobe, everything stays idle.
2. ch={100,50,20}, vol all 15, mute=0, strobe at T -> o_busy high from T+1 to T+4; o_sample_valid only at T+5; o_sample=170, o_clipped=0.
3. ch={200,100,0}, vol all 15 -> with MIXER_SATURATE_EN, o_sample=255, o_clipped=1; without it, o_sample=44, o_clipped=1.
4. ch={100,300,400}, vol={7,15,15}, mute=3'b110 -> o_sample=50 (100*8/16), o_clipped=0. Changing i_channels during ACCUM does not change the result.
5. Strobe, then a second strobe 2 cycles later and another in the DONE cycle -> exactly one valid pulse with the first mix's value; o_overrun=1 and stays set; the next strobe in IDLE mixes normally.
6. Assert i_rst during ACCUM -> o_busy=0 and o_sample=0 immediately, no valid pulse. A subsequent strobe with case-2 inputs yields 170 at T+5.
